// File: rtl/router_out_arbiter_if.sv
// router_out_arbiter_if
//   Bundles the request side and the output side of one router output
//   channel. The arbiter connects through the slave modport. Request
//   sources and the downstream router slice connect through the master
//   modport.
//
//   req_valid/req_head/req_tail : per-input flit valid and packet markers
//   req_flit                    : concatenated flits, input i at [i*FLIT_W +: FLIT_W]
//   req_ready                   : per-input accept, combinational
//   credit_in                   : one-cycle pulse, downstream freed one slot
//   out_valid/out_flit          : registered flit toward the router slice
//   grant_idx                   : current or most recent owner
//   locked                      : multi-flit packet holds the channel
//   credit_cnt                  : available downstream credits
//   error                       : sticky protocol-error flag
interface router_out_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = 68
) ();
  localparam int IDX_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]        req_valid;
  logic [NUM_IN-1:0]        req_head;
  logic [NUM_IN-1:0]        req_tail;
  logic [NUM_IN*FLIT_W-1:0] req_flit;
  logic [NUM_IN-1:0]        req_ready;
  logic                     credit_in;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic [IDX_W-1:0]         grant_idx;
  logic                     locked;
  logic [3:0]               credit_cnt;
  logic                     error;

  modport master (
    output req_valid, req_head, req_tail, req_flit, credit_in,
    input  req_ready, out_valid, out_flit, grant_idx, locked, credit_cnt, error
  );

  modport slave (
    input  req_valid, req_head, req_tail, req_flit, credit_in,
    output req_ready, out_valid, out_flit, grant_idx, locked, credit_cnt, error
  );
endinterface

// File: rtl/router_out_arbiter.sv
// router_out_arbiter
//   Shares one FLIT_W-bit output channel among NUM_IN requesters. Packets
//   are granted round-robin among inputs presenting a head flit. Once
//   granted, a packet owns the channel until its tail flit is accepted.
//   A downstream credit counter (BUF_DEPTH slots) gates every accept.
//   Protocol violations set a sticky error flag: a head flit arriving
//   inside an owned packet, or a credit returned while the count is full.
//
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : router_out_arbiter_if.slave (request inputs, req_ready,
//            registered output flit, grant/lock/credit/error status)
module router_out_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int FLIT_W    = 68,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  router_out_arbiter_if.slave  bus
);
  localparam int         IDX_W      = $clog2(NUM_IN);
  localparam logic [3:0] CREDIT_MAX = 4'(BUF_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]  grant, grant_next;
  logic [3:0]        credit, credit_next;
  logic              err, err_next;
  logic              credit_ovf;

  logic [NUM_IN-1:0] ready;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  sel;
  int                idx;
  logic              sel_head;
  logic              sel_tail;

  logic [FLIT_W-1:0] flits_p0 [NUM_IN];
  logic              vld_p0;
  logic              vld_p1;
  logic [FLIT_W-1:0] flit_p1;

  // Modulo-NUM_IN increment; NUM_IN need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_IN - 1)) wrap_inc = '0;
    else                         wrap_inc = i + IDX_W'(1);
  endfunction

  // Returns {overflow, next_count}. A returned credit that coincides with
  // a transfer cancels out. A credit returned at a full count saturates
  // and reports overflow. Decrement only happens on a transfer, and a
  // transfer needs a non-zero count, so the count never underflows.
  function automatic logic [4:0] credit_update(input logic [3:0] cnt,
                                               input logic       inc,
                                               input logic       dec);
    credit_update = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CREDIT_MAX) credit_update = {1'b1, cnt};
      else                   credit_update = {1'b0, cnt + 4'd1};
    end else if (!inc && dec) begin
      credit_update = {1'b0, cnt - 4'd1};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flits_p0[i] = bus.req_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Stage p0: arbitration, accept decision and next-state
  always_comb begin
    ready       = '0;
    found       = 1'b0;
    win         = '0;
    cand        = '0;
    idx         = 0;
    sel         = grant;
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_next  = grant;
    err_next    = err;

    // First head-flit requester at or after rr_ptr, wrapping around.
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      cand = IDX_W'(idx);
      if (!found && bus.req_valid[cand] && bus.req_head[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    if (state == IDLE) begin
      sel = win;
      if (found && credit != 4'd0) ready[win] = 1'b1;
    end else begin
      // Only the owner may move while the channel is locked.
      sel = grant;
      if (credit != 4'd0) ready[grant] = 1'b1;
    end

    vld_p0   = |(bus.req_valid & ready);
    sel_head = bus.req_head[sel];
    sel_tail = bus.req_tail[sel];

    if (vld_p0) begin
      grant_next = sel;
      if (state == IDLE) begin
        if (!sel_tail) state_next  = LOCKED;
        else           rr_ptr_next = wrap_inc(sel);
      end else begin
        // A stray head inside a packet is forwarded but flagged.
        if (sel_head) err_next = 1'b1;
        if (sel_tail) begin
          state_next  = IDLE;
          rr_ptr_next = wrap_inc(sel);
        end
      end
    end

    {credit_ovf, credit_next} = credit_update(credit, bus.credit_in, vld_p0);
    if (credit_ovf) err_next = 1'b1;
  end

  // Stage p1: registered output flit and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      credit  <= CREDIT_MAX;
      err     <= 1'b0;
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_ptr_next;
      grant   <= grant_next;
      credit  <= credit_next;
      err     <= err_next;
      vld_p1  <= vld_p0;
      if (vld_p0) flit_p1 <= flits_p0[sel];
    end
  end

  assign bus.req_ready  = ready;
  assign bus.out_valid  = vld_p1;
  assign bus.out_flit   = flit_p1;
  assign bus.grant_idx  = grant;
  assign bus.locked     = (state == LOCKED);
  assign bus.credit_cnt = credit;
  assign bus.error      = err;
endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter
//   Directed table of per-cycle vectors: inputs are driven just after a
//   rising edge. req_ready is compared mid-cycle. The registered outputs
//   are compared just after the following edge. Flit data for input i is
//   {i, base}, so the expected out_flit also identifies the winner.
module tb_router_out_arbiter;
  localparam int NUM_IN = 4;
  localparam int FLIT_W = 68;

  logic clk;
  logic reset;

  router_out_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) ifc ();

  router_out_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .BUF_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pre_rst;
    logic [3:0]  v, h, t;
    logic        cin;
    logic [63:0] base;
    logic [3:0]  rdy;
    logic        ov;
    logic [67:0] fl;
    logic [1:0]  g;
    logic        lk;
    logic [3:0]  cnt;
    logic        er;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit pr, input logic [3:0] v, input logic [3:0] h,
                     input logic [3:0] t, input logic cin, input logic [63:0] base,
                     input logic [3:0] rdy, input logic ov, input logic [67:0] fl,
                     input logic [1:0] g, input logic lk, input logic [3:0] cnt,
                     input logic er, input string nm);
    vec_t r;
    r.pre_rst = pr; r.v = v; r.h = h; r.t = t; r.cin = cin; r.base = base;
    r.rdy = rdy; r.ov = ov; r.fl = fl; r.g = g; r.lk = lk; r.cnt = cnt;
    r.er = er; r.name = nm;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                       input logic cin, input logic [63:0] base);
    ifc.req_valid = v;
    ifc.req_head  = h;
    ifc.req_tail  = t;
    ifc.credit_in = cin;
    for (int i = 0; i < NUM_IN; i++) ifc.req_flit[i*FLIT_W +: FLIT_W] = {4'(i), base};
  endtask

  // Called just after a rising edge; the async checks land before the
  // next edge, so they only hold if reset acts without a clock.
  task automatic do_reset(input string nm);
    drive(4'b0, 4'b0, 4'b0, 1'b0, 64'h0);
    reset = 1'b1;
    #2;
    chk({nm, "/out_valid"},  {67'h0, ifc.out_valid}, 68'h0);
    chk({nm, "/locked"},     {67'h0, ifc.locked},    68'h0);
    chk({nm, "/credit_cnt"}, {64'h0, ifc.credit_cnt}, 68'h4);
    chk({nm, "/error"},      {67'h0, ifc.error},     68'h0);
    chk({nm, "/grant_idx"},  {66'h0, ifc.grant_idx}, 68'h0);
    chk({nm, "/out_flit"},   ifc.out_flit,           68'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive(4'b0, 4'b0, 4'b0, 1'b0, 64'h0);

    // single-flit packet, rr_ptr advance, credit corner cases
    add(0, 4'b0100, 4'b0100, 4'b0100, 0, 64'h1234, 4'b0100, 1, {4'h2, 64'h1234}, 2, 0, 3, 0, "single_in2");
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,    4'b0000, 0, {4'h2, 64'h1234}, 2, 0, 3, 0, "idle_hold");
    add(0, 4'b1001, 4'b1001, 4'b1001, 0, 64'hA3,   4'b1000, 1, {4'h3, 64'hA3},   3, 0, 2, 0, "rr_from3");
    add(0, 4'b0011, 4'b0011, 4'b0011, 1, 64'hB4,   4'b0001, 1, {4'h0, 64'hB4},   0, 0, 2, 0, "credit_and_xfer");
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'h0,    4'b0000, 0, {4'h0, 64'hB4},   0, 0, 3, 0, "credit_ret1");
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'h0,    4'b0000, 0, {4'h0, 64'hB4},   0, 0, 4, 0, "credit_ret2");
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'h0,    4'b0000, 0, {4'h0, 64'hB4},   0, 0, 4, 1, "credit_overflow");
    // wormhole lock: input 1 held off until input 0's tail
    add(1, 4'b0011, 4'b0011, 4'b0000, 0, 64'hC1,   4'b0001, 1, {4'h0, 64'hC1},   0, 1, 3, 0, "pkt_head");
    add(0, 4'b0011, 4'b0010, 4'b0000, 0, 64'hC2,   4'b0001, 1, {4'h0, 64'hC2},   0, 1, 2, 0, "pkt_body");
    add(0, 4'b0011, 4'b0010, 4'b0001, 0, 64'hC3,   4'b0001, 1, {4'h0, 64'hC3},   0, 0, 1, 0, "pkt_tail");
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 64'hC4,   4'b0010, 1, {4'h1, 64'hC4},   1, 0, 1, 0, "next_head");
    // credit exhaustion and single-credit release
    add(1, 4'b0001, 4'b0001, 4'b0000, 0, 64'hD1,   4'b0001, 1, {4'h0, 64'hD1},   0, 1, 3, 0, "stream1");
    add(0, 4'b0001, 4'b0000, 4'b0000, 0, 64'hD2,   4'b0001, 1, {4'h0, 64'hD2},   0, 1, 2, 0, "stream2");
    add(0, 4'b0001, 4'b0000, 4'b0000, 0, 64'hD3,   4'b0001, 1, {4'h0, 64'hD3},   0, 1, 1, 0, "stream3");
    add(0, 4'b0001, 4'b0000, 4'b0000, 0, 64'hD4,   4'b0001, 1, {4'h0, 64'hD4},   0, 1, 0, 0, "stream4");
    add(0, 4'b0001, 4'b0000, 4'b0000, 1, 64'hD5,   4'b0000, 0, {4'h0, 64'hD4},   0, 1, 1, 0, "no_credit");
    add(0, 4'b0001, 4'b0000, 4'b0000, 0, 64'hD5,   4'b0001, 1, {4'h0, 64'hD5},   0, 1, 0, 0, "one_more");
    add(0, 4'b0001, 4'b0000, 4'b0001, 0, 64'hD6,   4'b0000, 0, {4'h0, 64'hD5},   0, 1, 0, 0, "stalled");
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'h0,    4'b0000, 0, {4'h0, 64'hD5},   0, 1, 1, 0, "credit_back");
    add(0, 4'b0001, 4'b0001, 4'b0000, 0, 64'hE9,   4'b0001, 1, {4'h0, 64'hE9},   0, 1, 0, 1, "second_head");
    // reset lands mid-packet here, then all inputs contend continuously
    add(1, 4'b1111, 4'b1111, 4'b1111, 1, 64'hF1,   4'b0001, 1, {4'h0, 64'hF1},   0, 0, 4, 0, "rr0");
    add(0, 4'b1111, 4'b1111, 4'b1111, 1, 64'hF2,   4'b0010, 1, {4'h1, 64'hF2},   1, 0, 4, 0, "rr1");
    add(0, 4'b1111, 4'b1111, 4'b1111, 1, 64'hF3,   4'b0100, 1, {4'h2, 64'hF3},   2, 0, 4, 0, "rr2");
    add(0, 4'b1111, 4'b1111, 4'b1111, 1, 64'hF4,   4'b1000, 1, {4'h3, 64'hF4},   3, 0, 4, 0, "rr3");
    add(0, 4'b1111, 4'b1111, 4'b1111, 1, 64'hF5,   4'b0001, 1, {4'h0, 64'hF5},   0, 0, 4, 0, "rr4");

    #1;
    do_reset("reset_init");

    foreach (vecs[n]) begin
      if (vecs[n].pre_rst) do_reset({vecs[n].name, "/pre_reset"});
      drive(vecs[n].v, vecs[n].h, vecs[n].t, vecs[n].cin, vecs[n].base);
      #5;
      chk({vecs[n].name, "/req_ready"}, {64'h0, ifc.req_ready}, {64'h0, vecs[n].rdy});
      @(posedge clk);
      #1;
      chk({vecs[n].name, "/out_valid"},  {67'h0, ifc.out_valid},  {67'h0, vecs[n].ov});
      chk({vecs[n].name, "/out_flit"},   ifc.out_flit,            vecs[n].fl);
      chk({vecs[n].name, "/grant_idx"},  {66'h0, ifc.grant_idx},  {66'h0, vecs[n].g});
      chk({vecs[n].name, "/locked"},     {67'h0, ifc.locked},     {67'h0, vecs[n].lk});
      chk({vecs[n].name, "/credit_cnt"}, {64'h0, ifc.credit_cnt}, {64'h0, vecs[n].cnt});
      chk({vecs[n].name, "/error"},      {67'h0, ifc.error},      {67'h0, vecs[n].er});
    end

    // Owner idles while locked: a competing head must stay blocked and
    // nothing is emitted, then the owner's tail releases the channel.
    // rr_ptr is 1 and credit_cnt is 4 after the rotation above.
    drive(4'b0010, 4'b0010, 4'b0000, 1'b0, 64'h77);
    @(posedge clk); #1;
    chk("own_head/locked", {67'h0, ifc.locked}, 68'h1);
    chk("own_head/grant",  {66'h0, ifc.grant_idx}, 68'h1);
    chk("own_head/credit", {64'h0, ifc.credit_cnt}, 68'h3);
    for (int c = 0; c < 2; c++) begin
      drive(4'b0100, 4'b0100, 4'b0100, 1'b0, 64'h88);
      #5;
      chk("owner_idle/ready2", {67'h0, ifc.req_ready[2]}, 68'h0);
      @(posedge clk); #1;
      chk("owner_idle/out_valid", {67'h0, ifc.out_valid}, 68'h0);
      chk("owner_idle/locked",    {67'h0, ifc.locked},    68'h1);
      chk("owner_idle/credit",    {64'h0, ifc.credit_cnt}, 68'h3);
    end
    drive(4'b0110, 4'b0100, 4'b0110, 1'b0, 64'h99);
    #5;
    chk("owner_tail/ready", {64'h0, ifc.req_ready}, 68'h2);
    @(posedge clk); #1;
    chk("owner_tail/out_flit", ifc.out_flit, {4'h1, 64'h99});
    chk("owner_tail/locked",   {67'h0, ifc.locked}, 68'h0);
    drive(4'b0100, 4'b0100, 4'b0100, 1'b0, 64'hAA);
    #5;
    chk("after_tail/ready", {64'h0, ifc.req_ready}, 68'h4);
    @(posedge clk); #1;
    chk("after_tail/grant",    {66'h0, ifc.grant_idx}, 68'h2);
    chk("after_tail/out_flit", ifc.out_flit, {4'h2, 64'hAA});
    chk("after_tail/credit",   {64'h0, ifc.credit_cnt}, 68'h1);
    drive(4'b0, 4'b0, 4'b0, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Output-port arbiter and credit controller placed in front of one router slice output channel.
- Shares one FLIT_W-bit output channel among NUM_IN input requesters using round-robin arbitration with wormhole locking: a granted packet holds the channel from its head flit through its tail flit.
- Tracks downstream buffer credits so no flit is sent without space.
- Flags protocol errors through a sticky error output.

Parameters:
- NUM_IN, 4, number of requesting inputs (2..8).
- FLIT_W, 68, flit width in bits; matches the router channel width.
- BUF_DEPTH, 4, downstream buffer depth; initial and maximum credit count (1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_IN  per-input flit valid.
- req_head  input  NUM_IN  per-input head-flit marker, qualified by req_valid.
- req_tail  input  NUM_IN  per-input tail-flit marker; head and tail both set means a single-flit packet.
- req_flit  input  NUM_IN*FLIT_W  flits, concatenated; input i occupies bits [i*FLIT_W +: FLIT_W].
- req_ready  output  NUM_IN  per-input accept, combinational.
- credit_in  input  1  one-cycle pulse; the downstream buffer freed one slot.
- out_valid  output  1  registered flit valid toward the router slice.
- out_flit  output  FLIT_W  registered flit data.
- grant_idx  output  clog2(NUM_IN)  index of the current or most recent owner.
- locked  output  1  high while a multi-flit packet holds the channel.
- credit_cnt  output  4  available downstream credits.
- error  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, active-high): state IDLE, out_valid=0, out_flit=0, grant_idx=0, locked=0, credit_cnt=BUF_DEPTH, rr_ptr=0, error=0. Asserting reset mid-packet drops the lock immediately. No flit is emitted in the reset cycle.
- States:
  - IDLE (locked=0).
  - LOCKED (locked=1, owner=grant_idx).
- IDLE selection:
  - Candidates are inputs with req_valid&req_head.
  - Search order is rr_ptr, rr_ptr+1, … modulo NUM_IN; the first candidate wins.
  - Winner w gets req_ready[w]=1 only if credit_cnt>0. All other req_ready are 0.
  - Non-head valid flits in IDLE are never accepted and do not set error.
- Transfer: occurs when req_valid[i]&req_ready[i]. On the next edge:
  - out_valid=1 and out_flit=req_flit[i].
  - grant_idx=i.
  - credit_cnt decrements, unless credit_in is also high.
- Latency: exactly one cycle from accepted input to out_valid. With no transfer, out_valid=0 on the next edge and out_flit holds its last value.
- Transitions:
  - IDLE→LOCKED on a transfer with head=1, tail=0.
  - IDLE stays IDLE on a transfer with head=1, tail=1; rr_ptr=w+1 mod NUM_IN.
  - LOCKED: only the owner may get req_ready, and only when credit_cnt>0. Every other input is held off even if it has a head flit.
  - LOCKED→IDLE on a transfer of the owner's tail flit; rr_ptr=owner+1 mod NUM_IN.
  - LOCKED with no owner valid, or no credit: no transfer; state, lock and rr_ptr hold.
- Protocol error: in LOCKED, an owner transfer with head=1 is still forwarded, the lock is kept (it releases if tail=1), and error=1.
- Credits:
  - credit_cnt_next = credit_cnt + credit_in − transfer.
  - Simultaneous credit_in and transfer leave the count unchanged.
  - When credit_cnt=0, all req_ready=0. A credit arriving that cycle makes sending possible from the following cycle only.
  - credit_in while credit_cnt=BUF_DEPTH and no transfer: count saturates at BUF_DEPTH and error=1.
- error clears only on reset.
- Throughput: one flit per cycle while credits remain. Back-to-back packets from different inputs with no idle cycle: tail accepted in cycle n, next head accepted in cycle n+1.

Test Plan:
- Reset, then input 2 sends a single-flit packet (head=tail=1, flit=68'h1234) → req_ready[2]=1 in the same cycle; out_valid=1 and out_flit=68'h1234 next cycle; credit_cnt 4→3; locked stays 0; rr_ptr=3.
- Inputs 0 and 1 both present head flits at rr_ptr=0. Input 0 sends a 3-flit packet → input 1 is not ready for all 3 cycles; locked=1 until the tail. Input 1's head is accepted in the cycle after input 0's tail.
- No credit_in, input 0 streams 6 flits, BUF_DEPTH=4 → 4 flits accepted, then req_ready=0 with credit_cnt=0. One credit_in pulse → exactly one more flit accepted, starting the cycle after the pulse.
- credit_in coincident with a transfer at credit_cnt=2 → credit_cnt stays 2. credit_in at credit_cnt=4 with no transfer → credit_cnt stays 4 and error=1.
- Locked owner presents a second head mid-packet → flit is forwarded, error=1, lock is retained. Reset asserted mid-packet → locked=0, out_valid=0, credit_cnt=4 immediately (asynchronous).
- All 4 inputs send continuous single-flit packets → grants rotate 0,1,2,3,0 with one flit per cycle and no starvation.
